min2_accumulate: RTL

- Sequential stage directly downstream of the 4-to-2 nonzero-minimum selector.
- Consumes one selector result per beat (two candidate values plus 7-bit addresses) across a scan of NUM_GROUPS beats.
- Tracks the global two smallest nonzero values and their addresses, then presents them with their sum for the next merge step.
- Zero means empty slot. Selector outputs are unordered and may carry zeros.

---
 rtl/min2_accumulate.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/min2_accumulate.sv
//============================================================================
// Module   : min2_accumulate
// Purpose  : Scans NUM_GROUPS selector beats and keeps the two smallest
//            nonzero values with addresses; presents them with their sum.
//            Optional macro MIN2_ACC_SUM_SAT_EN saturates out_sum at 2^DATA_W-1.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module min2_accumulate #(
    parameter int DATA_W     = 11,
    parameter int ADDR_W     = 7,
    parameter int NUM_GROUPS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_min1,
    input  logic [DATA_W-1:0] in_min2,
    input  logic [ADDR_W-1:0] in_min1_addr,
    input  logic [ADDR_W-1:0] in_min2_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_min1,
    output logic [DATA_W-1:0] out_min2,
    output logic [ADDR_W-1:0] out_min1_addr,
    output logic [ADDR_W-1:0] out_min2_addr,
    output logic [DATA_W:0]   out_sum,
    output logic [1:0]        out_count,
    output logic              busy
);

    localparam int                CNT_W      = 7;
    localparam logic [CNT_W-1:0] c_LAST_BEAT = CNT_W'(NUM_GROUPS - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_SCAN = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]        r_state_q, w_state_d;
    logic [CNT_W-1:0]  r_cnt_q, w_cnt_d;
    logic [DATA_W-1:0] r_best1_q, w_best1_d, r_best2_q, w_best2_d;
    logic [ADDR_W-1:0] r_best1_addr_q, w_best1_addr_d, r_best2_addr_q, w_best2_addr_d;
    logic [DATA_W-1:0] r_out_min1_q, w_out_min1_d, r_out_min2_q, w_out_min2_d;
    logic [ADDR_W-1:0] r_out_min1_addr_q, w_out_min1_addr_d;
    logic [ADDR_W-1:0] r_out_min2_addr_q, w_out_min2_addr_d;
    logic [DATA_W:0]   r_out_sum_q, w_out_sum_d;
    logic [1:0]        r_out_count_q, w_out_count_d;

    logic              w_accept;
    logic              w_last;

    logic [DATA_W-1:0] w_cand_val  [4];
    logic [ADDR_W-1:0] w_cand_addr [4];
    logic [DATA_W:0]   w_cand_key  [4];
    logic [1:0]        w_sel1, w_sel2;
    logic              w_found2;
    logic [DATA_W-1:0] w_m1_val, w_m2_val;
    logic [ADDR_W-1:0] w_m1_addr, w_m2_addr;
    logic [DATA_W:0]   w_sum_exact, w_sum;
    logic [1:0]        w_count;

    assign w_accept = (r_state_q == c_ST_SCAN) && in_valid;
    assign w_last   = w_accept && (r_cnt_q == c_LAST_BEAT);

    // Candidate order doubles as tie priority; the key's top bit makes 0 sort as +infinity.
    always_comb begin
        w_cand_val[0]  = r_best1_q;
        w_cand_val[1]  = r_best2_q;
        w_cand_val[2]  = in_min1;
        w_cand_val[3]  = in_min2;
        w_cand_addr[0] = r_best1_addr_q;
        w_cand_addr[1] = r_best2_addr_q;
        w_cand_addr[2] = in_min1_addr;
        w_cand_addr[3] = in_min2_addr;
        for (int i = 0; i < 4; i++) begin
            w_cand_key[i] = {~|w_cand_val[i], w_cand_val[i]};
        end

        w_sel1 = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (w_cand_key[i] < w_cand_key[w_sel1]) begin
                w_sel1 = 2'(i);
            end
        end

        w_sel2   = 2'd0;
        w_found2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (2'(i) != w_sel1) begin
                if (!w_found2 || (w_cand_key[i] < w_cand_key[w_sel2])) begin
                    w_sel2   = 2'(i);
                    w_found2 = 1'b1;
                end
            end
        end

        w_m1_val  = w_cand_val[w_sel1];
        w_m2_val  = w_cand_val[w_sel2];
        w_m1_addr = (w_m1_val == '0) ? '0 : w_cand_addr[w_sel1];
        w_m2_addr = (w_m2_val == '0) ? '0 : w_cand_addr[w_sel2];
    end

    assign w_sum_exact = {1'b0, w_m1_val} + {1'b0, w_m2_val};

`ifdef MIN2_ACC_SUM_SAT_EN
    assign w_sum = w_sum_exact[DATA_W] ? {1'b0, {DATA_W{1'b1}}} : w_sum_exact;
`else
    assign w_sum = w_sum_exact;
`endif

    // best2 nonzero implies best1 nonzero, so the count follows from two tests.
    assign w_count = (w_m2_val != '0) ? 2'd2 : ((w_m1_val != '0) ? 2'd1 : 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= c_ST_IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            c_ST_IDLE: if (start)                  w_state_d = c_ST_SCAN;
            c_ST_SCAN: if (w_last)                 w_state_d = c_ST_DONE;
            c_ST_DONE: if (out_ready)              w_state_d = c_ST_IDLE;
            default:                               w_state_d = c_ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state_q == c_ST_SCAN);
        out_valid = (r_state_q == c_ST_DONE);
        busy      = (r_state_q == c_ST_SCAN) || (r_state_q == c_ST_DONE);
    end

    always_comb begin
        w_cnt_d           = r_cnt_q;
        w_best1_d         = r_best1_q;
        w_best2_d         = r_best2_q;
        w_best1_addr_d    = r_best1_addr_q;
        w_best2_addr_d    = r_best2_addr_q;
        w_out_min1_d      = r_out_min1_q;
        w_out_min2_d      = r_out_min2_q;
        w_out_min1_addr_d = r_out_min1_addr_q;
        w_out_min2_addr_d = r_out_min2_addr_q;
        w_out_sum_d       = r_out_sum_q;
        w_out_count_d     = r_out_count_q;
        if ((r_state_q == c_ST_IDLE) && start) begin
            w_cnt_d        = '0;
            w_best1_d      = '0;
            w_best2_d      = '0;
            w_best1_addr_d = '0;
            w_best2_addr_d = '0;
        end else if (w_accept) begin
            w_cnt_d        = r_cnt_q + 1'b1;
            w_best1_d      = w_m1_val;
            w_best2_d      = w_m2_val;
            w_best1_addr_d = w_m1_addr;
            w_best2_addr_d = w_m2_addr;
            if (w_last) begin
                w_out_min1_d      = w_m1_val;
                w_out_min2_d      = w_m2_val;
                w_out_min1_addr_d = w_m1_addr;
                w_out_min2_addr_d = w_m2_addr;
                w_out_sum_d       = w_sum;
                w_out_count_d     = w_count;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_q           <= '0;
            r_best1_q         <= '0;
            r_best2_q         <= '0;
            r_best1_addr_q    <= '0;
            r_best2_addr_q    <= '0;
            r_out_min1_q      <= '0;
            r_out_min2_q      <= '0;
            r_out_min1_addr_q <= '0;
            r_out_min2_addr_q <= '0;
            r_out_sum_q       <= '0;
            r_out_count_q     <= '0;
        end else begin
            r_cnt_q           <= w_cnt_d;
            r_best1_q         <= w_best1_d;
            r_best2_q         <= w_best2_d;
            r_best1_addr_q    <= w_best1_addr_d;
            r_best2_addr_q    <= w_best2_addr_d;
            r_out_min1_q      <= w_out_min1_d;
            r_out_min2_q      <= w_out_min2_d;
            r_out_min1_addr_q <= w_out_min1_addr_d;
            r_out_min2_addr_q <= w_out_min2_addr_d;
            r_out_sum_q       <= w_out_sum_d;
            r_out_count_q     <= w_out_count_d;
        end
    end

    assign out_min1      = r_out_min1_q;
    assign out_min2      = r_out_min2_q;
    assign out_min1_addr = r_out_min1_addr_q;
    assign out_min2_addr = r_out_min2_addr_q;
    assign out_sum       = r_out_sum_q;
    assign out_count     = r_out_count_q;

endmodule

`default_nettype wire
